reaction_timer_core: RTL and testbench
======================================

REACTION_TIMER_CORE -- requirements
Module: reaction_timer_core

Interface
REQ-001 Parameter TICKS_PER_MS, default 10000: clk cycles per 1 ms tick (10 MHz clock).
REQ-002 Parameter MIN_DELAY_MS, default 1000: minimum random foreperiod, in ms.
REQ-003 Parameter DELAY_BITS, default 12: LFSR bits added to MIN_DELAY_MS (range 0..2^DELAY_BITS-1 ms).
REQ-004 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_btn  input  1  raw start button (ui_in[0]), asynchronous to clk.
REQ-007 react_btn  input  1  raw react button (ui_in[1]), asynchronous to clk.
REQ-008 digits  output  16  four 4-bit display codes {d3,d2,d1,d0}, d3 = thousands; consumed by the 7-segment scan stage.
REQ-009 led  output  1  stimulus LED; 1 only in state GO.
REQ-010 state_o  output  3  current FSM state encoding.
REQ-011 result_valid  output  1  one-cycle pulse on entry to DONE.

Function
REQ-012 Each button passes through a 2-flop synchronizer, then rising-edge detection; the resulting 1-cycle pulse is the only event seen by the FSM.
REQ-013 An input held high produces exactly one pulse; the FSM acts on the 3rd rising clk edge after the input is first sampled high.
REQ-014 A free-running ms-tick counter counts 0..TICKS_PER_MS-1 and emits a 1-cycle tick at wrap; it is cleared on every FSM state change.
REQ-015 A 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every clk cycle and never reaches zero.
REQ-016 States: IDLE=0, WAIT=1, GO=2, DONE=3, FALSE=4; all other encodings return to IDLE next cycle.
REQ-017 IDLE: led=0, digits=16'h0000; start pulse -> WAIT.
REQ-018 Entering WAIT: load delay counter with MIN_DELAY_MS + LFSR[DELAY_BITS-1:0]; clear BCD count to 0000; digits show all-blank code 4'hF.
REQ-019 WAIT: each tick decrements the delay counter; a tick with the counter at 1 -> GO; react pulse -> FALSE; start pulse ignored.
REQ-020 GO: led=1; each tick increments a 4-digit BCD count with per-digit carry (9->0); digits show the live count.
REQ-021 GO: react pulse -> DONE with count frozen; if a tick and a react pulse coincide, react wins and the tick is not applied.
REQ-022 GO: count saturates at 9999; a tick at 9999 -> DONE with digits=16'h9999 (timeout).
REQ-023 DONE: led=0, digits hold the frozen count, result_valid=1 for the entry cycle only; start pulse -> WAIT.
REQ-024 FALSE: led=0, digits=16'hAAAA (code 4'hA = dash); start pulse -> WAIT.
REQ-025 Start and react pulses in the same cycle: react has priority in WAIT and GO; start acts in IDLE, DONE, FALSE.
REQ-026 React pulses in IDLE, DONE and FALSE are ignored.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, digits=16'h0000, led=0, result_valid=0, state_o=0, counters 0, synchronizer flops 0, LFSR=16'hACE1.
REQ-028 Reset asserted mid-trial (WAIT or GO) discards the trial; no result_valid pulse is produced.
REQ-029 Outputs are registered; after rst_n deasserts, the first state change occurs no earlier than the 3rd clk edge.

Structure
REQ-030 Package reaction_pkg holds the state encoding, digit codes (BLANK=4'hF, DASH=4'hA), LFSR seed and tap mask.
REQ-031 Sub-module reaction_btn_sync (2-flop sync + edge detect) is instantiated once per button.
REQ-032 The BCD counter, delay counter, LFSR and FSM remain inline in reaction_timer_core.

Verification (TICKS_PER_MS=4, MIN_DELAY_MS=2, DELAY_BITS=3)
REQ-033 Reset, then start pulse -> WAIT, digits=16'hFFFF; GO after (2+LFSR[2:0]) ms with led=1.
REQ-034 In GO, react after 37 ticks -> DONE, digits=16'h0037, result_valid high exactly 1 cycle, led=0.
REQ-035 React during WAIT -> FALSE, digits=16'hAAAA, led never 1; then start -> WAIT.
REQ-036 No react in GO -> count passes 0099->0100 and 0999->1000, saturates, DONE with 16'h9999.
REQ-037 Start and react rising together in GO -> DONE; held start produces one pulse only; rst_n low in GO -> IDLE asynchronously, digits=0000, no result_valid.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer: FSM state encoding, display
// digit codes, LFSR constants and the BCD increment helper.
package reaction_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_GO    = 3'd2,
      ST_DONE  = 3'd3,
      ST_FALSE = 3'd4
   } state_t;

   localparam logic [3:0]  DIGIT_BLANK = 4'hF;
   localparam logic [3:0]  DIGIT_DASH  = 4'hA;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS   = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // Four-digit BCD +1 with per-digit carry; saturation is the caller's job
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/reaction_btn_sync.sv
// Two-flop synchronizer for a raw button followed by rising-edge detection;
// a held button yields exactly one single-cycle pulse.
module reaction_btn_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_btn;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: random foreperiod, stimulus LED, BCD millisecond count of
// the response, false-start detection and registered display outputs.
module reaction_timer_core #(
   parameter int unsigned TICKS_PER_MS = 10000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned DELAY_BITS   = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_btn,
   input  logic        react_btn,
   output logic [15:0] digits,
   output logic        led,
   output logic [2:0]  state_o,
   output logic        result_valid
);

   import reaction_pkg::*;

   localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam int DLY_W  = $clog2(MIN_DELAY_MS + (2 ** DELAY_BITS)) + 1;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_state_change;
   logic [TICK_W-1:0]   r_tick_cnt;
   logic                w_tick;
   logic [DLY_W-1:0]    r_dly;
   logic [DLY_W-1:0]    w_dly_next;
   logic [DLY_W-1:0]    w_dly_load;
   logic [15:0]         r_bcd;
   logic [15:0]         w_bcd_next;
   logic [15:0]         r_lfsr;
   logic [15:0]         r_digits;
   logic [15:0]         w_digits_next;
   logic                r_led;
   logic                r_result_valid;
   logic [1:0]          w_btn_raw;
   logic [1:0]          w_pulse;
   logic                w_start;
   logic                w_react;

   assign w_btn_raw = {react_btn, start_btn};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         reaction_btn_sync u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (w_btn_raw[gi]),
            .o_pulse (w_pulse[gi])
         );
      end
   endgenerate

   assign w_start = w_pulse[0];
   assign w_react = w_pulse[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsr_step(r_lfsr);
      end
   end

   // Restarting the ms tick on every state change gives each phase whole ms
   assign w_tick         = (r_tick_cnt == TICK_W'(TICKS_PER_MS - 1));
   assign w_state_change = (w_state_next != r_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (w_state_change || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
   end

   assign w_dly_load = DLY_W'(MIN_DELAY_MS) + DLY_W'(r_lfsr[DELAY_BITS-1:0]);

   always_comb begin
      w_state_next = r_state;
      w_dly_next   = r_dly;
      w_bcd_next   = r_bcd;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_react) begin
               w_state_next = ST_FALSE;
            end else if (w_tick) begin
               if (r_dly <= DLY_W'(1)) w_state_next = ST_GO;
               w_dly_next = (r_dly == '0) ? '0 : r_dly - DLY_W'(1);
            end
         end
         ST_GO: begin
            // React beats a coincident tick so the frozen count is not bumped
            if (w_react) begin
               w_state_next = ST_DONE;
            end else if (w_tick) begin
               if (r_bcd == 16'h9999) w_state_next = ST_DONE;
               else                   w_bcd_next   = bcd_inc(r_bcd);
            end
         end
         ST_DONE, ST_FALSE: begin
            if (w_start) w_state_next = ST_WAIT;
         end
         default: w_state_next = ST_IDLE;
      endcase
      if ((w_state_next == ST_WAIT) && (r_state != ST_WAIT)) begin
         w_dly_next = w_dly_load;
         w_bcd_next = 16'h0000;
      end
   end

   always_comb begin
      w_digits_next = 16'h0000;
      case (w_state_next)
         ST_WAIT:        w_digits_next = {4{DIGIT_BLANK}};
         ST_GO, ST_DONE: w_digits_next = w_bcd_next;
         ST_FALSE:       w_digits_next = {4{DIGIT_DASH}};
         default:        w_digits_next = 16'h0000;
      endcase
   end

   // Outputs are registered from next-state values so they align with state_o
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_dly          <= '0;
         r_bcd          <= 16'h0000;
         r_digits       <= 16'h0000;
         r_led          <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_dly          <= w_dly_next;
         r_bcd          <= w_bcd_next;
         r_digits       <= w_digits_next;
         r_led          <= (w_state_next == ST_GO);
         r_result_valid <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
      end
   end

   assign digits       = r_digits;
   assign led          = r_led;
   assign state_o      = r_state;
   assign result_valid = r_result_valid;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core with 4 clk per ms, 2 ms minimum
// foreperiod and 3 random delay bits.
module tb_reaction_timer_core;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_GO    = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FALSE = 3'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_btn = 1'b0;
   logic        react_btn = 1'b0;
   logic [15:0] digits;
   logic        led;
   logic [2:0]  state_o;
   logic        result_valid;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   reaction_timer_core #(
      .TICKS_PER_MS (4),
      .MIN_DELAY_MS (2),
      .DELAY_BITS   (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_btn    (start_btn),
      .react_btn    (react_btn),
      .digits       (digits),
      .led          (led),
      .state_o      (state_o),
      .result_valid (result_valid)
   );

   // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, one step per clk
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("check %s ok val=%0h", tag, got);
      end
   endtask

   // lf returns the LFSR value of the cycle just before the state change
   task automatic wait_state(input logic [2:0] target, input int budget,
                             output int cycles, output logic [15:0] lf,
                             output logic led_seen);
      cycles   = 0;
      led_seen = 1'b0;
      lf       = m_lfsr;
      while (cycles < budget) begin
         @(negedge clk);
         cycles++;
         led_seen = led_seen | led;
         if (state_o == target) break;
         lf = m_lfsr;
      end
   endtask

   int          cyc;
   logic [15:0] lf_wait;
   logic [15:0] lf_tmp;
   logic        ls;
   logic [15:0] prev;
   logic        saw99;
   logic        saw999;
   logic        seen;
   int          n;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_state", state_o, S_IDLE);
      chk("rst_digits", digits, 16'h0000);
      chk("rst_led", led, 1'b0);
      chk("rst_rv", result_valid, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // React in IDLE is ignored
      react_btn = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_react", state_o, S_IDLE);
      react_btn = 1'b0;
      repeat (2) @(negedge clk);

      // Start -> WAIT after three edges, then GO after (2+lfsr[2:0]) ms
      start_btn = 1'b1;
      wait_state(S_WAIT, 10, cyc, lf_wait, ls);
      chk("wait_state", state_o, S_WAIT);
      chk("start_latency", cyc, 3);
      chk("wait_digits", digits, 16'hFFFF);
      chk("wait_led", led, 1'b0);
      start_btn = 1'b0;
      wait_state(S_GO, 100, cyc, lf_tmp, ls);
      chk("go_state", state_o, S_GO);
      chk("go_delay", cyc, (2 + int'(lf_wait[2:0])) * 4);
      chk("go_led", led, 1'b1);
      chk("go_digits", digits, 16'h0000);

      // React after 37 ticks
      n = 0;
      while (digits != 16'h0037 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("count_37", digits, 16'h0037);
      react_btn = 1'b1;
      wait_state(S_DONE, 10, cyc, lf_tmp, ls);
      chk("done_state", state_o, S_DONE);
      chk("react_latency", cyc, 3);
      chk("done_digits", digits, 16'h0037);
      chk("done_rv", result_valid, 1'b1);
      chk("done_led", led, 1'b0);
      @(negedge clk);
      chk("rv_one_cycle", result_valid, 1'b0);
      react_btn = 1'b0;
      repeat (2) @(negedge clk);

      // False start: react during WAIT
      start_btn = 1'b1;
      wait_state(S_WAIT, 10, cyc, lf_tmp, ls);
      chk("fs_wait", state_o, S_WAIT);
      start_btn = 1'b0;
      repeat (2) @(negedge clk);
      react_btn = 1'b1;
      wait_state(S_FALSE, 10, cyc, lf_tmp, ls);
      chk("false_state", state_o, S_FALSE);
      chk("false_digits", digits, 16'hAAAA);
      chk("false_led_seen", ls, 1'b0);
      react_btn = 1'b0;
      repeat (2) @(negedge clk);
      react_btn = 1'b1;
      repeat (6) @(negedge clk);
      chk("false_react_ignored", state_o, S_FALSE);
      react_btn = 1'b0;
      repeat (2) @(negedge clk);
      start_btn = 1'b1;
      wait_state(S_WAIT, 10, cyc, lf_wait, ls);
      chk("false_to_wait", state_o, S_WAIT);
      chk("false_to_wait_digits", digits, 16'hFFFF);
      start_btn = 1'b0;

      // Timeout: count runs to 9999 through the decade carries
      wait_state(S_GO, 100, cyc, lf_tmp, ls);
      chk("to_go_state", state_o, S_GO);
      chk("to_go_delay", cyc, (2 + int'(lf_wait[2:0])) * 4);
      prev   = digits;
      saw99  = 1'b0;
      saw999 = 1'b0;
      n      = 0;
      while (state_o != S_DONE && n < 50000) begin
         @(negedge clk);
         n++;
         if (digits !== prev) begin
            if (prev == 16'h0099) begin
               chk("carry_0099", digits, 16'h0100);
               saw99 = 1'b1;
            end
            if (prev == 16'h0999) begin
               chk("carry_0999", digits, 16'h1000);
               saw999 = 1'b1;
            end
            prev = digits;
         end
      end
      chk("to_done_state", state_o, S_DONE);
      chk("to_digits", digits, 16'h9999);
      chk("to_rv", result_valid, 1'b1);
      chk("to_led", led, 1'b0);
      chk("saw_0099", saw99, 1'b1);
      chk("saw_0999", saw999, 1'b1);
      repeat (2) @(negedge clk);

      // Start and react together in GO; held start must not re-trigger
      start_btn = 1'b1;
      wait_state(S_WAIT, 10, cyc, lf_tmp, ls);
      start_btn = 1'b0;
      wait_state(S_GO, 100, cyc, lf_tmp, ls);
      chk("both_go", state_o, S_GO);
      repeat (3) @(negedge clk);
      start_btn = 1'b1;
      react_btn = 1'b1;
      wait_state(S_DONE, 10, cyc, lf_tmp, ls);
      chk("both_done", state_o, S_DONE);
      chk("both_latency", cyc, 3);
      repeat (20) @(negedge clk);
      chk("held_start", state_o, S_DONE);
      start_btn = 1'b0;
      react_btn = 1'b0;
      repeat (3) @(negedge clk);

      // Asynchronous reset during GO
      start_btn = 1'b1;
      wait_state(S_WAIT, 10, cyc, lf_tmp, ls);
      start_btn = 1'b0;
      wait_state(S_GO, 100, cyc, lf_tmp, ls);
      chk("rst_go", state_o, S_GO);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", state_o, S_IDLE);
      chk("arst_digits", digits, 16'h0000);
      chk("arst_led", led, 1'b0);
      chk("arst_rv", result_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | result_valid | (state_o != S_IDLE);
      end
      chk("post_rst_quiet", seen, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
